apb_to_ahb: RTL
===============

Name: apb_to_ahb

Overview:
- Single-clock APB3 completer that turns each APB transfer into one AHB-Lite/AHB2 single-word initiator transfer.
- Lets APB-side agents, such as the APB master BFM and test sequencers, reach AHB memories and slaves through the shared bus fabric.
- Complements the existing AHB-to-APB bridge path.
- Handles bus request/grant, wait states, and ERROR/RETRY/SPLIT responses.

Parameters:
P_HADDR_BASE, 32'h0000_0000, OR-ed onto the masked APB address to form HADDR
P_ADDR_MASK, 32'h0000_FFFC, applied to PADDR; bits [1:0] are always cleared
P_HPROT, 4'b0011, constant HPROT value (data, privileged)
P_GRANT_TIMEOUT, 16, maximum cycles spent in REQ before abort; 0 disables the timeout

Ports:
HCLK  in  1  single clock for both the APB and AHB sides
HRESET  in  1  synchronous, active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PADDR  in  32  APB address
PWRITE  in  1  APB direction
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  APB transfer done
PSLVERR  out  1  APB error
HBUSREQ  out  1  AHB bus request
HGRANT  in  1  AHB grant
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type
HWRITE  out  1  AHB direction
HSIZE  out  3  always 3'b010 (word)
HBURST  out  3  always 3'b000 (SINGLE)
HPROT  out  4  equals P_HPROT
HLOCK  out  1  always 0
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HREADY  in  1  AHB ready
HRESP  in  2  AHB response: OKAY=00, ERROR=01, RETRY=10, SPLIT=11

Behaviour:
- The clock is HCLK. Reset is HRESET: synchronous, active-high. Every flop below resets on the rising HCLK edge where HRESET=1.
- Reset values:
  - state=IDLE
  - PRDATA=0, PREADY=0, PSLVERR=0
  - HBUSREQ=0, HTRANS=IDLE(2'b00), HADDR=0, HWRITE=0, HWDATA=0
  - grant counter=0
- All outputs are registered or decoded from the state register only. There is no combinational path from AHB inputs to APB outputs.
- Latch rule: at an edge with state=IDLE and PSEL=1 and PENABLE=0, capture:
  - HADDR_r = (PADDR & P_ADDR_MASK) | P_HADDR_BASE, with [1:0] forced to 0
  - PWRITE and PWDATA
  - then go to REQ.
- FSM:
  - IDLE: waits for the latch rule.
  - REQ:
    - Drives HBUSREQ=1 and HTRANS=IDLE.
    - Edge with HGRANT=1 and HREADY=1: go to ADDR.
    - Otherwise the counter increments. When P_GRANT_TIMEOUT≠0 and counter reaches P_GRANT_TIMEOUT: set err, go to RESP.
    - Counter clears when leaving REQ.
  - ADDR:
    - Drives HBUSREQ=1, HTRANS=NONSEQ(2'b10), HADDR/HWRITE from the latch, HSIZE/HBURST/HPROT constants.
    - Edge with HREADY=1: go to DATA.
    - If HGRANT is lost while HREADY=1, go back to REQ instead.
  - DATA:
    - Drives HTRANS=IDLE and HBUSREQ=0. HWDATA holds the latched write data.
    - Edge with HREADY=1 and HRESP=OKAY: PRDATA<=HRDATA on reads only (writes leave PRDATA unchanged), err=0, go to RESP.
    - Edge with HREADY=0 and HRESP=ERROR: set err, wait for the second response cycle, then go to RESP.
    - Edge with HREADY=0 and HRESP=RETRY or SPLIT: go to REQ and reissue the identical transfer. Retries are unlimited.
  - RESP:
    - PREADY=1 and PSLVERR=err, for exactly one cycle.
    - Next edge: go to IDLE, PREADY=0, PSLVERR=0.
- Minimum latency, with grant already present and zero-wait AHB:
  - setup edge T0 → REQ
  - T1 → ADDR
  - T2 → DATA
  - T3 → RESP
  - PREADY sampled high at T4.
- A new transfer is accepted only in IDLE. Setup phases presented in other states are ignored; a legal APB master cannot produce them.
- PSEL deasserted mid-transfer (protocol violation): the AHB transfer still completes and PREADY still pulses once.
- HRESET mid-operation: return to IDLE next edge with all outputs at reset values. A truncated AHB transfer is accepted.
- HRDATA is ignored on writes. PWDATA is never used directly on the AHB; only the latched copy is driven.

Test Plan:
- Write, zero-wait, HGRANT tied to HBUSREQ:
  - Stimulus: PADDR=0x0000_0010, PWDATA=0xDEAD_BEEF.
  - Required: HTRANS=NONSEQ with HADDR=0x10 and HWRITE=1 one cycle, HWDATA=0xDEAD_BEEF in the next cycle, PREADY=1 and PSLVERR=0 at T4.
- Read with 3 wait states, slave returning 0x1234_5678:
  - Required: PRDATA=0x1234_5678, and PREADY rises exactly 3 cycles later than in the zero-wait case.
- Read with two-cycle ERROR response:
  - Required: PSLVERR=1 coincident with the single PREADY pulse, and PRDATA unchanged.
- RETRY once, then OKAY:
  - Required: HBUSREQ reasserts, a second NONSEQ is issued with the same HADDR/HWRITE, and a single PREADY pulse follows with PSLVERR=0.
- HGRANT held 0, P_GRANT_TIMEOUT=16:
  - Required: exactly 16 cycles of HBUSREQ=1, then PREADY=1 with PSLVERR=1, and HTRANS never NONSEQ.
- HRESET=1 asserted in DATA:
  - Required: next edge gives HTRANS=0, HBUSREQ=0, PREADY=0; a subsequent write to 0x20 completes normally.

Source files
------------

// File: rtl/apb_to_ahb.sv
// -----------------------------------------------------------------------------
// apb_to_ahb
//   APB3 completer that forwards every APB transfer as one single-word
//   AHB-Lite/AHB2 initiator transfer. It requests the bus, waits for grant,
//   issues one NONSEQ and returns the result on the APB side. Wait states are
//   handled, as are ERROR (two-cycle), RETRY and SPLIT responses, plus an
//   optional grant timeout. HCLK clocks both the APB side and the AHB side.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   PSEL..PWDATA          APB completer inputs
//   PRDATA/PREADY/PSLVERR APB completer outputs (registered or state-decoded)
//   HBUSREQ/HGRANT        AHB arbitration handshake
//   HADDR..HWDATA         AHB initiator address/control/write data
//   HRDATA/HREADY/HRESP   AHB slave response inputs
//
// Parameters
//   P_HADDR_BASE     OR-ed onto the masked APB address
//   P_ADDR_MASK      applied to PADDR; bits [1:0] are always cleared
//   P_HPROT          constant HPROT value
//   P_GRANT_TIMEOUT  maximum number of cycles spent in REQ (0 = wait forever)
// -----------------------------------------------------------------------------
module apb_to_ahb #(
   parameter logic [31:0] P_HADDR_BASE    = 32'h0000_0000,
   parameter logic [31:0] P_ADDR_MASK     = 32'h0000_FFFC,
   parameter logic [3:0]  P_HPROT         = 4'b0011,
   parameter int unsigned P_GRANT_TIMEOUT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic [31:0] PADDR,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        HBUSREQ,
   input  logic        HGRANT,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic [1:0]  HRESP
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_DERR = 3'd4;  // second cycle of a two-cycle ERROR
   localparam logic [2:0] S_RESP = 3'd5;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   localparam logic [1:0] RSP_OKAY  = 2'b00;
   localparam logic [1:0] RSP_ERROR = 2'b01;

   localparam logic [31:0] TIMEOUT  = 32'(P_GRANT_TIMEOUT);

   logic [2:0]  state;
   logic [31:0] grant_cnt;
   logic        err;

   // Control outputs are decoded from the state register only, so the AHB
   // inputs never reach the APB outputs through combinational logic.
   assign HBUSREQ = (state == S_REQ) || (state == S_ADDR);
   assign HTRANS  = (state == S_ADDR) ? TR_NONSEQ : TR_IDLE;
   assign PREADY  = (state == S_RESP);
   assign PSLVERR = (state == S_RESP) && err;

   assign HSIZE   = 3'b010;
   assign HBURST  = 3'b000;
   assign HPROT   = P_HPROT;
   assign HLOCK   = 1'b0;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= S_IDLE;
         grant_cnt <= '0;
         err       <= 1'b0;
         PRDATA    <= '0;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // APB setup phase: latch the whole request. Only the latched
               // copy is driven onto the AHB side.
               if (PSEL && !PENABLE) begin
                  HADDR  <= ((PADDR & P_ADDR_MASK) | P_HADDR_BASE) & ~32'h3;
                  HWRITE <= PWRITE;
                  HWDATA <= PWDATA;
                  err    <= 1'b0;
                  state  <= S_REQ;
               end
            end

            S_REQ: begin
               if (HGRANT && HREADY) begin
                  grant_cnt <= '0;
                  state     <= S_ADDR;
               end else if ((TIMEOUT != 32'd0) && (grant_cnt == TIMEOUT - 32'd1)) begin
                  // This is the TIMEOUT-th cycle without a grant: give up.
                  grant_cnt <= '0;
                  err       <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  grant_cnt <= grant_cnt + 32'd1;
               end
            end

            S_ADDR: begin
               // The address phase only completes on HREADY. If the grant was
               // removed meanwhile, the transfer was not ours: request again.
               if (HREADY) begin
                  state <= HGRANT ? S_DATA : S_REQ;
               end
            end

            S_DATA: begin
               if (HREADY) begin
                  if (HRESP == RSP_OKAY) begin
                     if (!HWRITE) PRDATA <= HRDATA;
                     err <= 1'b0;
                  end else begin
                     // A one-cycle non-OKAY response is illegal on AHB;
                     // report it as an error instead of hanging.
                     err <= 1'b1;
                  end
                  state <= S_RESP;
               end else if (HRESP == RSP_ERROR) begin
                  err   <= 1'b1;
                  state <= S_DERR;
               end else if (HRESP != RSP_OKAY) begin
                  // RETRY or SPLIT: reissue the same latched transfer.
                  state <= S_REQ;
               end
            end

            S_DERR: begin
               if (HREADY) state <= S_RESP;
            end

            S_RESP: begin
               err   <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
